// File: rtl/gcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gcd_pkg                                                      |
// | Description : Shared types for the GCD issue path. Holds the issue-queue   |
// |               FSM state type and a helper that packs an operand pair into  |
// |               one FIFO word (A in the upper half, B in the lower half).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package gcd_pkg;

    typedef enum logic [1:0] {
        IQ_IDLE = 2'd0,
        IQ_LOAD = 2'd1,
        IQ_WAIT = 2'd2
    } issue_state_t;

    localparam int C_DEF_XLEN = 32;

    // Packs operand A above operand B so the FIFO head splits back cleanly.
    function automatic logic [2*C_DEF_XLEN-1:0] pack_pair(
        input logic [C_DEF_XLEN-1:0] a,
        input logic [C_DEF_XLEN-1:0] b
    );
        return {a, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gcd_fifo                                                     |
// | Description : Synchronous FIFO with registered storage and a              |
// |               combinational read of the head entry.                        |
// |   clk_i/rst_i : clock, synchronous active-high reset                       |
// |   push_i      : write din_i (ignored when full)                            |
// |   pop_i       : drop the head entry (ignored when empty)                   |
// |   dout_o      : current head entry                                         |
// |   full_o/empty_o/count_o : occupancy status                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gcd_fifo
    import gcd_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when indices coincide.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Full is judged on the pre-pop state: a same-cycle pop never frees a slot.
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i  & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/gcd_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gcd_issue_queue                                              |
// | Description : Buffers operand pairs from a valid/ready producer and issues |
// |               them to the GCD core one at a time (load pulse, then wait    |
// |               for done).                                                   |
// |   s_valid_i/s_ready_o/s_a_i/s_b_i : producer side                          |
// |   core_ld_o/core_a_o/core_b_o     : load strobe and registered operands    |
// |   core_ready_i/core_valid_i       : core idle / core done                  |
// |   count_o, busy_o                 : FIFO occupancy, FSM not idle           |
// |   Optional macro GCD_ISSUE_PERF_EN adds cyc_cnt_o (busy cycles, 64b) and   |
// |   ops_cnt_o (completed ops, 32b).                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gcd_issue_queue
    import gcd_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [XLEN-1:0]         s_a_i,
    input  logic [XLEN-1:0]         s_b_i,
    output logic                    core_ld_o,
    output logic [XLEN-1:0]         core_a_o,
    output logic [XLEN-1:0]         core_b_o,
    input  logic                    core_ready_i,
    input  logic                    core_valid_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    busy_o
`ifdef GCD_ISSUE_PERF_EN
    ,
    output logic [63:0]             cyc_cnt_o,
    output logic [31:0]             ops_cnt_o
`endif
);

    issue_state_t          state_q;
    issue_state_t          state_d;
    logic                  wait_first_q;
    logic [XLEN-1:0]       core_a_q;
    logic [XLEN-1:0]       core_b_q;
    logic [2*XLEN-1:0]     w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_start;

    gcd_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (s_valid_i),
        .pop_i   (state_q == IQ_LOAD),
        .din_i   ({s_a_i, s_b_i}),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (count_o)
    );

    assign s_ready_o = ~w_full;
    assign core_ld_o = (state_q == IQ_LOAD);
    assign core_a_o  = core_a_q;
    assign core_b_o  = core_b_q;
    assign busy_o    = (state_q != IQ_IDLE);
    assign w_start   = (state_q == IQ_IDLE) && !w_empty && core_ready_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IQ_IDLE: if (w_start) state_d = IQ_LOAD;
            IQ_LOAD: state_d = IQ_WAIT;
            // The first WAIT cycle may still see the previous op's done.
            IQ_WAIT: if (!wait_first_q && core_valid_i) state_d = IQ_IDLE;
            default: state_d = IQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IQ_IDLE;
            wait_first_q <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            wait_first_q <= (state_q == IQ_LOAD);
            // Capture the head on entry to LOAD; held until the next LOAD.
            if (w_start) begin
                core_a_q <= w_head[2*XLEN-1:XLEN];
                core_b_q <= w_head[XLEN-1:0];
            end
        end
    end

`ifdef GCD_ISSUE_PERF_EN
    logic [63:0] cyc_cnt_q;
    logic [31:0] ops_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt_q <= '0;
            ops_cnt_q <= '0;
        end else begin
            if (state_q != IQ_IDLE) cyc_cnt_q <= cyc_cnt_q + 64'd1;
            if ((state_q == IQ_WAIT) && (state_d == IQ_IDLE)) ops_cnt_q <= ops_cnt_q + 32'd1;
        end
    end

    assign cyc_cnt_o = cyc_cnt_q;
    assign ops_cnt_o = ops_cnt_q;
`endif

endmodule
`default_nettype wire
